// File: rtl/pc2drone_pkg.sv
// pc2drone_pkg: shared types and default timing for the Pc2Drone PWM path
//   WIDTH_BITS  - width of a scaled pulse-width sample
//   CNT_BITS    - width of the PWM frame counter
//   pwm_state_t - IDLE/HIGH/LOW servo_pwm state encoding
//   DEF_*       - 12 MHz clock defaults: 20 ms frame, 1 ms base pulse
package pc2drone_pkg;
  localparam int unsigned WIDTH_BITS = 15;
  localparam int unsigned CNT_BITS = 18;
  typedef logic [WIDTH_BITS-1:0] width_t;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} pwm_state_t;
  localparam int unsigned CLK_HZ = 12_000_000;
  localparam int unsigned DEF_PERIOD_CYCLES = CLK_HZ / 50;
  localparam int unsigned DEF_BASE_CYCLES = CLK_HZ / 1000;
  localparam int unsigned DEF_MAX_WIDTH = 12288;
  localparam int unsigned DEF_NEUTRAL_WIDTH = 6144;
  localparam int unsigned DEF_TIMEOUT_FRAMES = 25;
endpackage

// File: rtl/servo_pwm_if.sv
// servo_pwm_if: scaled pulse-width sample stream into servo_pwm
//   sink_data_valid - single-cycle strobe qualifying sink_data
//   sink_data       - scaled width in clock cycles
//   master drives the stream, slave (servo_pwm) consumes it; no backpressure
interface servo_pwm_if;
  import pc2drone_pkg::*;
  logic sink_data_valid;
  width_t sink_data;
  modport master (output sink_data_valid, sink_data);
  modport slave (input sink_data_valid, sink_data);
endinterface

// File: rtl/pwm_frame_timer.sv
// pwm_frame_timer: PWM frame counter with wrap plus end-of-pulse/end-of-frame compares
//   clk, reset - clock and synchronous active-low reset
//   hold       - keeps the counter at 0 (idle)
//   width      - active width added to the base pulse
//   pulse_end  - last high cycle of the pulse
//   frame_end  - last cycle of the frame
module pwm_frame_timer
  import pc2drone_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned BASE_CYCLES = DEF_BASE_CYCLES
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  width_t width,
  output logic   pulse_end,
  output logic   frame_end
);
  logic [CNT_BITS-1:0] cnt;
  assign frame_end = cnt == CNT_BITS'(PERIOD_CYCLES - 1);
  // 18-bit sum: base plus a full 15-bit width cannot overflow
  assign pulse_end = cnt == CNT_BITS'(BASE_CYCLES) + CNT_BITS'(width) - CNT_BITS'(1);
  always_ff @(posedge clk)
    if (!reset) cnt <= '0;
    else cnt <= (hold || frame_end) ? '0 : cnt + CNT_BITS'(1);
endmodule

// File: rtl/servo_pwm.sv
// servo_pwm: RC servo/ESC pulse generator with double-buffered width samples
//   clk, reset  - clock and synchronous active-low reset
//   enable      - output enable, honoured only at frame boundaries
//   sink        - servo_pwm_if.slave sample stream (clamped to MAX_WIDTH)
//   pwm_out     - registered pulse, high for BASE_CYCLES + active width
//   frame_start - one-cycle strobe on frame cycle 0
//   failsafe    - neutral width substituted (only with PWM_FAILSAFE_EN defined)
module servo_pwm
  import pc2drone_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned BASE_CYCLES = DEF_BASE_CYCLES,
  parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int unsigned NEUTRAL_WIDTH = DEF_NEUTRAL_WIDTH,
  parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  servo_pwm_if.slave   sink,
  output logic         pwm_out,
  output logic         frame_start,
  output logic         failsafe
);
`ifdef PWM_FAILSAFE_EN
  localparam width_t RST_WIDTH = width_t'(NEUTRAL_WIDTH);
`else
  localparam width_t RST_WIDTH = '0;
`endif
  pwm_state_t state, state_n;
  width_t pending, pending_n, active, clamped;
  logic load, pulse_end, frame_end;
  assign clamped = sink.sink_data > width_t'(MAX_WIDTH) ? width_t'(MAX_WIDTH) : sink.sink_data;
  pwm_frame_timer #(.PERIOD_CYCLES(PERIOD_CYCLES), .BASE_CYCLES(BASE_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .hold(state == IDLE),
    .width(active),
    .pulse_end(pulse_end),
    .frame_end(frame_end)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (enable ? HIGH : IDLE)
            : state == HIGH ? (pulse_end ? LOW : HIGH)
            : frame_end ? (enable ? HIGH : IDLE) : LOW;
    load = state_n == HIGH && state != HIGH;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      pwm_out <= 1'b0;
      frame_start <= 1'b0;
      active <= RST_WIDTH;
      pending <= RST_WIDTH;
    end else begin
      state <= state_n;
      pwm_out <= state_n == HIGH;
      frame_start <= load;
      if (load) active <= pending;
      pending <= pending_n;
    end
`ifdef PWM_FAILSAFE_EN
  logic [7:0] tcnt, tcnt_n;
  logic got, fs;
  // got remembers a sample since the last load; a sample on the load edge counts for the next frame
  always_comb begin
    tcnt_n = tcnt;
    tcnt_n = sink.sink_data_valid ? '0
           : (load && !got && tcnt != 8'(TIMEOUT_FRAMES)) ? tcnt + 8'd1 : tcnt;
    pending_n = sink.sink_data_valid ? clamped
              : tcnt_n == 8'(TIMEOUT_FRAMES) ? width_t'(NEUTRAL_WIDTH) : pending;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      tcnt <= '0;
      got <= 1'b0;
      fs <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      got <= sink.sink_data_valid || (got && !load);
      fs <= !sink.sink_data_valid && (fs || tcnt_n == 8'(TIMEOUT_FRAMES));
    end
  assign failsafe = fs;
`else
  logic unused_cfg;
  assign unused_cfg = NEUTRAL_WIDTH != TIMEOUT_FRAMES;
  assign pending_n = sink.sink_data_valid ? clamped : pending;
  assign failsafe = 1'b0;
`endif
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: directed, table-driven check of servo_pwm pulse widths, framing, enable and reset
module tb_servo_pwm;
`ifdef PWM_FAILSAFE_EN
  localparam int RST_W = 20;
  localparam int FS_EXP = 1;
`else
  localparam int RST_W = 0;
  localparam int FS_EXP = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic pwm_out, frame_start, failsafe;
  int errs = 0;
  int checks = 0;
  servo_pwm_if sink();
  servo_pwm #(
    .PERIOD_CYCLES(100), .BASE_CYCLES(10), .MAX_WIDTH(40),
    .NEUTRAL_WIDTH(20), .TIMEOUT_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sink(sink.slave),
    .pwm_out(pwm_out), .frame_start(frame_start), .failsafe(failsafe)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [14:0] sample;
    int exp_high;
  } vec_t;
  vec_t vecs[7];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Starts on frame cycle 0 (sampled at negedge); runs to the next frame_start.
  // Injects a one-cycle sample on frame cycles i1 and i2 (-1 = none).
  task automatic measure(input int i1, input logic [14:0] d1, input int i2,
                         input logic [14:0] d2, output int hi, output int len);
    hi = 0;
    len = 0;
    do begin
      sink.sink_data_valid = (len == i1) || (len == i2);
      sink.sink_data = (len == i2) ? d2 : d1;
      hi += int'(pwm_out);
      len++;
      @(negedge clk);
    end while (!frame_start && len < 400);
    sink.sink_data_valid = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int hi, len, prev;
    vecs[0] = '{15'd25, 35};
    vecs[1] = '{15'd200, 50};
    vecs[2] = '{15'd0, 10};
    vecs[3] = '{15'd40, 50};
    vecs[4] = '{15'd41, 50};
    vecs[5] = '{15'd39, 49};
    vecs[6] = '{15'd32767, 50};
    sink.sink_data_valid = 1'b0;
    sink.sink_data = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_failsafe", int'(failsafe), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pwm", int'(pwm_out), 0);
    enable = 1'b1;
    @(negedge clk);
    check("first_frame_start", int'(frame_start), 1);
    check("first_pwm", int'(pwm_out), 1);
    measure(-1, 0, -1, 0, hi, len);
    check("first_high", hi, 10 + RST_W);
    check("first_len", len, 100);
    prev = 10 + RST_W;
    foreach (vecs[i]) begin
      measure(30, vecs[i].sample, -1, 0, hi, len);
      check("vec_old_high", hi, prev);
      check("vec_old_len", len, 100);
      measure(-1, 0, -1, 0, hi, len);
      check("vec_new_high", hi, vecs[i].exp_high);
      check("vec_new_len", len, 100);
      prev = vecs[i].exp_high;
    end
    measure(20, 15'd5, 99, 15'd30, hi, len);
    check("dbl_cur_high", hi, prev);
    measure(-1, 0, -1, 0, hi, len);
    check("dbl_first_high", hi, 15);
    check("dbl_first_len", len, 100);
    measure(-1, 0, -1, 0, hi, len);
    check("dbl_second_high", hi, 40);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 3) enable = 1'b0;
      hi += int'(pwm_out);
      @(negedge clk);
    end
    check("dis_high", hi, 40);
    check("dis_no_fs", int'(frame_start), 0);
    check("dis_pwm", int'(pwm_out), 0);
    repeat (5) @(negedge clk);
    check("dis_idle_pwm", int'(pwm_out), 0);
    check("dis_idle_fs", int'(frame_start), 0);
    enable = 1'b1;
    @(negedge clk);
    check("reen_fs", int'(frame_start), 1);
    check("reen_pwm", int'(pwm_out), 1);
    sink.sink_data_valid = 1'b1;
    sink.sink_data = 15'd33;
    @(negedge clk);
    check("fs_one_cycle", int'(frame_start), 0);
    sink.sink_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_pwm", int'(pwm_out), 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_fs", int'(frame_start), 0);
    check("midrst_failsafe", int'(failsafe), 0);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_fs", int'(frame_start), 1);
    measure(-1, 0, -1, 0, hi, len);
    check("postrst_high", hi, 10 + RST_W);
    measure(-1, 0, -1, 0, hi, len);
    check("to2_high", hi, 10 + RST_W);
    check("to2_failsafe", int'(failsafe), FS_EXP);
    measure(40, 15'd8, -1, 0, hi, len);
    check("to3_high", hi, 10 + RST_W);
    check("to3_len", len, 100);
    check("sample_failsafe", int'(failsafe), 0);
    measure(-1, 0, -1, 0, hi, len);
    check("after_fs_high", hi, 18);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/servo_pwm.md
# servo_pwm

Servo/ESC pulse generator that consumes the 15-bit scaled pulse-width samples produced by the Pc2Drone channel scaler and drives one RC-style PWM output. Each output period is a fixed base pulse plus the latest accepted width; new samples are double-buffered and take effect only at a period boundary. With the 12 MHz system clock the defaults give a 20 ms frame and a 1 ms base pulse. Scaled samples span 0..12240 cycles, so the total pulse is about 1–2 ms.

## Interface
- PERIOD_CYCLES, 240000 — clock cycles per PWM frame; must exceed BASE_CYCLES + MAX_WIDTH.
- BASE_CYCLES, 12000 — fixed high time at the start of every pulse.
- MAX_WIDTH, 12288 — clamp ceiling for the accepted width.
- NEUTRAL_WIDTH, 6144 — failsafe width; used only when PWM_FAILSAFE_EN is defined.
- TIMEOUT_FRAMES, 25 — frames without a sample before failsafe triggers; used only when PWM_FAILSAFE_EN is defined.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  output enable; sampled only at frame boundaries.
- sink_data_valid  input  1  single-cycle strobe that qualifies sink_data.
- sink_data  input  15  scaled width in clock cycles.
- pwm_out  output  1  PWM pulse, registered.
- frame_start  output  1  one-cycle strobe on the first cycle of each active frame.
- failsafe  output  1  high while the neutral width is substituted; tied 0 when the feature is compiled out.

## Operation
- Reset (reset == 0) values:
  - pwm_out = 0, frame_start = 0, failsafe = 0.
  - State = IDLE, frame counter = 0, timeout counter = 0.
  - pending width = active width = NEUTRAL_WIDTH when PWM_FAILSAFE_EN is defined, otherwise 0.
- Sample capture: on each sink_data_valid, pending <= min(sink_data, MAX_WIDTH). The newest sample wins, and no backpressure exists.
- State machine:
  - IDLE: pwm_out = 0, counter held at 0. If enable = 1, go to HIGH on the next cycle; that cycle is frame cycle 0.
  - HIGH: pwm_out = 1 while counter < BASE_CYCLES + active. When counter == BASE_CYCLES + active − 1, go to LOW.
  - LOW: pwm_out = 0 until counter == PERIOD_CYCLES − 1.
  - Frame end in LOW: counter wraps to 0. If enable = 1, go to HIGH; if enable = 0, go to IDLE.
- Frame load, on every transition into HIGH (frame cycle 0):
  - active <= pending.
  - frame_start = 1 for that one cycle.
- Arithmetic:
  - Frame counter is 18 bits and never exceeds PERIOD_CYCLES − 1.
  - The pulse-end compare uses BASE_CYCLES + active at 18-bit width, so no overflow occurs.
- Width 0: the pulse is exactly BASE_CYCLES high.
- Deasserting enable mid-frame does not truncate the frame; the current frame completes.
- Reset mid-pulse: pwm_out goes low on the next edge and all pending data is discarded.

## Timing
- pwm_out and frame_start are registered; pwm_out rises in the same cycle frame_start is high.
- A sample accepted at edge t is in pending after t.
- A sample whose valid coincides with the frame-load edge goes to the next frame. That load uses the pre-edge pending value.
- Capture-to-output latency: at least 1 cycle, at most PERIOD_CYCLES + 1 cycles.
- High time of a frame = BASE_CYCLES + active cycles exactly. Frame length = PERIOD_CYCLES cycles exactly.

## Configuration
- Macro: PWM_FAILSAFE_EN.
- Defined:
  - The timeout counter clears on any sink_data_valid and increments at each frame load without a valid since the previous load.
  - When it reaches TIMEOUT_FRAMES, pending is forced to NEUTRAL_WIDTH and failsafe = 1.
  - The next sink_data_valid clears failsafe in the same cycle pending updates.
  - Reset width is NEUTRAL_WIDTH.
- Undefined: no timeout logic, failsafe tied 0, and the last sample is held indefinitely.

## Structure
- Shared package pc2drone_pkg holds:
  - State encoding constants (IDLE/HIGH/LOW).
  - The 15-bit width type/constant WIDTH_BITS.
  - Default timing constants (12 MHz clock, 20 ms frame, 1 ms base).
- One sub-module, pwm_frame_timer: the frame counter with wrap and its end-of-pulse and end-of-frame compares. servo_pwm keeps the FSM, buffering and failsafe.

## Test plan
All scenarios use PERIOD_CYCLES=100, BASE_CYCLES=10, MAX_WIDTH=40, NEUTRAL_WIDTH=20, TIMEOUT_FRAMES=3.
- Enable with a single sample 25 mid-frame -> current frame keeps the old width; the next frame is high exactly 35 cycles, period 100.
- Sample 200 -> clamped; high exactly 50 cycles. Sample 0 -> high exactly 10 cycles.
- Samples 5 then 30 within one frame, with 30 arriving on the frame-load edge -> next frame uses 5 (10+5 = 15 high); the following frame uses 30 (40 high).
- Deassert enable at frame cycle 3 -> full frame completes, then IDLE with pwm_out 0. Re-enable -> frame_start on the next cycle.
- Reset asserted at cycle 5 of HIGH -> pwm_out 0 on the next edge, all outputs at reset values.
- PWM_FAILSAFE_EN with no samples for 3 frames -> failsafe = 1 and 30-cycle pulses. A sample of 8 -> failsafe = 0 and 18-cycle pulses from the following frame.
